// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps a 4:1 mux through channels 0-3, waits dwell settle cycles on each,
// samples mux_y and publishes a 4-bit frame; SCAN_CHANGE_DETECT_EN adds a frame-change pulse.
module mux_scan_sampler #(
   parameter int DWELL_W      = 4,
   parameter bit AUTO_RESTART = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               mux_y,
   output logic [1:0]         mux_sel,
   output logic [3:0]         frame,
   output logic               frame_valid,
   output logic               busy
`ifdef SCAN_CHANGE_DETECT_EN
   ,
   output logic               changed
`endif
);
   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
   state_t state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
   logic [3:0] shadow_q, shadow_d, frame_q, frame_d;
   logic fv_q, fv_d;
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      dwell_d  = dwell_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      fv_d     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = SETTLE;
            sel_d   = 2'd0;
            cnt_d   = dwell;
            dwell_d = dwell;
         end
         SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else begin
            shadow_d[sel_q] = mux_y;
            if (sel_q != 2'd3) begin
               sel_d = sel_q + 2'd1;
               cnt_d = dwell_q;
            end else begin
               // shadow_d already holds channel 3, so the frame never shows a partial scan
               frame_d = shadow_d;
               fv_d    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: if (AUTO_RESTART) begin
            state_d = SETTLE;
            sel_d   = 2'd0;
            cnt_d   = dwell;
            dwell_d = dwell;
         end else state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= 2'd0;
         cnt_q    <= '0;
         dwell_q  <= '0;
         shadow_q <= 4'd0;
         frame_q  <= 4'd0;
         fv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         dwell_q  <= dwell_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
      end
   end
   assign mux_sel     = sel_q;
   assign frame       = frame_q;
   assign frame_valid = fv_q;
   assign busy        = state_q != IDLE;
`ifdef SCAN_CHANGE_DETECT_EN
   // frame_q still holds the previous frame on the edge that loads the new one
   logic changed_q, changed_d;
   assign changed_d = fv_d && (frame_d != frame_q);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) changed_q <= 1'b0;
      else changed_q <= changed_d;
   end
   assign changed = changed_q;
`endif
endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb_mux_scan_sampler: checks a one-shot and an auto-restart instance against a scan-timing model.
module tb_mux_scan_sampler;
   logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
   logic [3:0] d = 4'd0, dwell = 4'd0;
   logic [1:0] sel0, sel1;
   logic [3:0] frame0, frame1;
   logic fv0, fv1, busy0, busy1, y0, y1;
`ifdef SCAN_CHANGE_DETECT_EN
   logic chg0, chg1;
   logic last_chg0;
`endif
   assign y0 = d[sel0];
   assign y1 = d[sel1];
   always #5 clk = ~clk;

   mux_scan_sampler #(.DWELL_W(4), .AUTO_RESTART(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .dwell(dwell), .mux_y(y0),
      .mux_sel(sel0), .frame(frame0), .frame_valid(fv0), .busy(busy0)
`ifdef SCAN_CHANGE_DETECT_EN
      , .changed(chg0)
`endif
   );
   mux_scan_sampler #(.DWELL_W(4), .AUTO_RESTART(1'b1)) dut_auto (
      .clk(clk), .rst_n(rst_n), .start(start1), .dwell(dwell), .mux_y(y1),
      .mux_sel(sel1), .frame(frame1), .frame_valid(fv1), .busy(busy1)
`ifdef SCAN_CHANGE_DETECT_EN
      , .changed(chg1)
`endif
   );

   int errors = 0, checks = 0, cyc = 0;
   // scan model: n counts edges since the accepting edge, p = dwell+1 cycles per channel
   int n_m[2], p_m[2];
   bit busy_m[2], fv_m[2], chg_m[2];
   logic [1:0] sel_m[2];
   logic [3:0] acc_m[2], frame_m[2];
   int e0, fv_cnt0, first_fv0, last_fv0, busy_cnt0;
   logic [7:0] sel_hist;
   int e1, n1 = 0, busy1_low = 0;
   bit auto_on = 0, dchg = 0;
   int fv1_cyc[8];
   logic [3:0] fv1_frame[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         n_m[i] = 0; p_m[i] = 1; busy_m[i] = 0; fv_m[i] = 0; chg_m[i] = 0;
         sel_m[i] = 2'd0; acc_m[i] = 4'd0; frame_m[i] = 4'd0;
      end
   endtask

   task automatic model_edge(input int i, input bit st);
      int k;
      fv_m[i] = 0;
      chg_m[i] = 0;
      if (!busy_m[i]) begin
         if (st) begin busy_m[i] = 1; n_m[i] = 0; p_m[i] = int'(dwell) + 1; end
      end else if (n_m[i] == 4 * p_m[i]) begin
         if (i == 1) begin n_m[i] = 0; p_m[i] = int'(dwell) + 1; end
         else busy_m[i] = 0;
      end else begin
         n_m[i]++;
         if (n_m[i] % p_m[i] == 0) begin
            k = n_m[i] / p_m[i] - 1;
            acc_m[i][k] = d[k];
         end
         if (n_m[i] == 4 * p_m[i]) begin
            chg_m[i] = acc_m[i] != frame_m[i];
            frame_m[i] = acc_m[i];
            fv_m[i] = 1;
         end
      end
      if (busy_m[i]) sel_m[i] = n_m[i] < 4 * p_m[i] ? 2'(n_m[i] / p_m[i]) : 2'd3;
   endtask

   task automatic compare_all();
      chk("sel0", sel0, sel_m[0]);     chk("sel1", sel1, sel_m[1]);
      chk("busy0", busy0, busy_m[0]);  chk("busy1", busy1, busy_m[1]);
      chk("fv0", fv0, fv_m[0]);        chk("fv1", fv1, fv_m[1]);
      chk("frame0", frame0, frame_m[0]); chk("frame1", frame1, frame_m[1]);
`ifdef SCAN_CHANGE_DETECT_EN
      chk("chg0", chg0, chg_m[0]);     chk("chg1", chg1, chg_m[1]);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin model_edge(0, start0); model_edge(1, start1); end
      cyc++;
      #1;
      compare_all();
      if (fv0) begin
         fv_cnt0++;
         if (fv_cnt0 == 1) first_fv0 = cyc;
         last_fv0 = cyc;
`ifdef SCAN_CHANGE_DETECT_EN
         last_chg0 = chg0;
`endif
      end
      if (busy0) busy_cnt0++;
      if (cyc >= e0 && cyc < e0 + 4) sel_hist = {sel_hist[5:0], sel0};
      if (fv1 && n1 < 8) begin fv1_cyc[n1] = cyc; fv1_frame[n1] = frame1; n1++; end
      if (auto_on && !busy1) busy1_low++;
   endtask

   task automatic begin0(input logic [3:0] dv, input logic [3:0] dw);
      d = dv; dwell = dw; start0 = 1'b1; e0 = cyc + 1;
      fv_cnt0 = 0; first_fv0 = -1; busy_cnt0 = 0; sel_hist = 8'd0;
`ifdef SCAN_CHANGE_DETECT_EN
      last_chg0 = 1'bx;
`endif
      tick();
      start0 = 1'b0;
   endtask

   initial begin
      model_reset();
      e0 = -100;
      repeat (2) tick();
      chk("rst_sel", sel0, 2'd0); chk("rst_frame", frame0, 4'd0);
      chk("rst_busy", busy0, 1'b0); chk("rst_fv", fv0, 1'b0);
      rst_n = 1'b1;
      tick();
      // single scan, dwell 0
      begin0(4'b0101, 4'd0); repeat (8) tick();
      chk("t1_frame", frame0, 4'b0101); chk("t1_lat", first_fv0 - e0, 4);
      chk("t1_cnt", fv_cnt0, 1); chk("t1_busy", busy_cnt0, 5);
      chk("t1_sel_seq", sel_hist, 8'b00_01_10_11);
      // dwell 3
      begin0(4'b1010, 4'd3); repeat (20) tick();
      chk("t2_frame", frame0, 4'b1010); chk("t2_lat", first_fv0 - e0, 16);
      chk("t2_busy", busy_cnt0, 17); chk("t2_cnt", fv_cnt0, 1);
      // start and dwell changes while busy are ignored
      begin0(4'b0110, 4'd2); repeat (3) tick();
      start0 = 1'b1; dwell = 4'd7; repeat (3) tick();
      start0 = 1'b0; repeat (10) tick();
      chk("t3_cnt", fv_cnt0, 1); chk("t3_lat", first_fv0 - e0, 12);
      chk("t3_frame", frame0, 4'b0110); chk("t3_busy", busy_cnt0, 13);
      // start held high: period 4*(dwell+1)+2
      begin0(4'b0011, 4'd0); start0 = 1'b1; repeat (13) tick();
      start0 = 1'b0; repeat (8) tick();
      chk("t4_cnt", fv_cnt0, 3); chk("t4_lat", first_fv0 - e0, 4);
      chk("t4_period2", last_fv0 - first_fv0, 12); chk("t4_frame", frame0, 4'b0011);
      // maximum dwell
      begin0(4'b1001, 4'd15); repeat (70) tick();
      chk("t5_lat", first_fv0 - e0, 64); chk("t5_frame", frame0, 4'b1001);
      chk("t5_busy", busy_cnt0, 65);
      // asynchronous reset during channel 2
      begin0(4'b1111, 4'd2); repeat (6) tick();
      chk("rm_sel_pre", sel0, 2'd2);
      rst_n = 1'b0; #1;
      chk("rm_sel", sel0, 2'd0); chk("rm_busy", busy0, 1'b0);
      chk("rm_frame", frame0, 4'd0); chk("rm_fv", fv0, 1'b0);
      model_reset(); fv_cnt0 = 0;
      repeat (2) tick();
      rst_n = 1'b1; repeat (15) tick();
      chk("rm_no_fv", fv_cnt0, 0);
`ifdef SCAN_CHANGE_DETECT_EN
      begin0(4'b0000, 4'd0); repeat (6) tick(); chk("cd_0", last_chg0, 1'b0);
      begin0(4'b0000, 4'd0); repeat (6) tick(); chk("cd_1", last_chg0, 1'b0);
      begin0(4'b0110, 4'd0); repeat (6) tick(); chk("cd_2", last_chg0, 1'b1);
`endif
      // auto restart, dwell 1
      d = 4'b0001; dwell = 4'd1; start1 = 1'b1;
      tick();
      start1 = 1'b0; auto_on = 1; e1 = cyc;
      repeat (30) begin
         tick();
         if (n1 == 1 && !dchg) begin d = 4'b1111; dchg = 1; end
      end
      chk("ar_cnt", n1, 3); chk("ar_lat", fv1_cyc[0] - e1, 8);
      chk("ar_gap1", fv1_cyc[1] - fv1_cyc[0], 9); chk("ar_gap2", fv1_cyc[2] - fv1_cyc[1], 9);
      chk("ar_frame0", fv1_frame[0], 4'b0001); chk("ar_frame1", fv1_frame[1], 4'b1111);
      chk("ar_busy", busy1_low, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
